// File: rtl/sumsqr_window_acc_pkg.sv
// Shared definitions for the sum-of-squares datapath and its windowed accumulator.
package sumsqr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_WIN_LEN = 16;

    // Window sum cannot exceed WIN_LEN * (2^DATA_W - 1), so log2(WIN_LEN) extra bits suffice.
    function automatic int calc_acc_w(input int data_w, input int win_len);
        return data_w + $clog2(win_len);
    endfunction

    function automatic int calc_cnt_w(input int win_len);
        return $clog2(win_len) + 1;
    endfunction

endpackage

// File: rtl/sumsqr_window_acc_if.sv
// Sample-in / result-out handshake bundle of the windowed accumulator.
interface sumsqr_window_acc_if
    import sumsqr_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = calc_acc_w(DEF_DATA_W, DEF_WIN_LEN),
    parameter int CNT_W  = calc_cnt_w(DEF_WIN_LEN)
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              flush;
    logic [ACC_W-1:0]  out_sum;
    logic [CNT_W-1:0]  out_count;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_data, in_valid, flush, out_ready,
        input  in_ready, out_sum, out_count, out_valid
    );

    modport slave (
        input  in_data, in_valid, flush, out_ready,
        output in_ready, out_sum, out_count, out_valid
    );
endinterface

// File: rtl/sumsqr_window_acc.sv
// Sums the sum-of-squares result stream over fixed windows of WIN_LEN samples;
// a flush closes a non-empty window early. Results are held until taken.
module sumsqr_window_acc
    import sumsqr_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int WIN_LEN = DEF_WIN_LEN,
    parameter int ACC_W   = calc_acc_w(DATA_W, WIN_LEN),
    parameter int CNT_W   = calc_cnt_w(WIN_LEN)
) (
    input logic                clock,
    input logic                reset,
    sumsqr_window_acc_if.slave bus
);

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [ACC_W-1:0]   r_out_sum;
    logic [CNT_W-1:0]   r_out_count;
    logic               r_out_valid;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_transfer;
    logic [ACC_W-1:0]   w_new_acc;
    logic [CNT_W-1:0]   w_new_cnt;
    logic               w_close;

    // Held low while reset is asserted so no sample is taken during reset.
    assign w_in_ready = reset && (r_state != HOLD);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_transfer = r_out_valid && bus.out_ready;

    always_comb begin
        w_new_acc = r_acc;
        w_new_cnt = r_cnt;
        if (w_accept) begin
            w_new_acc = r_acc + ACC_W'(bus.in_data);
            w_new_cnt = r_cnt + CNT_W'(1);
        end
    end

    // An empty window (IDLE flush without a sample) never closes.
    always_comb begin
        w_close = 1'b0;
        if (r_state != HOLD) begin
            w_close = (w_accept && (w_new_cnt == CNT_W'(WIN_LEN)))
                   || (bus.flush && (w_new_cnt != '0));
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_sum   <= '0;
            r_out_count <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE, ACCUM: begin
                    r_acc <= w_new_acc;
                    r_cnt <= w_new_cnt;
                    if (w_close) begin
                        r_out_sum   <= w_new_acc;
                        r_out_count <= w_new_cnt;
                        r_out_valid <= 1'b1;
                        r_state     <= HOLD;
                    end else if (w_new_cnt != '0) begin
                        r_state <= ACCUM;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                HOLD: begin
                    if (w_transfer) begin
                        r_out_valid <= 1'b0;
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_sum   = r_out_sum;
    assign bus.out_count = r_out_count;
    assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_sumsqr_window_acc.sv
// Directed bench for sumsqr_window_acc with WIN_LEN=4 and WIN_LEN=16 instances.
module tb_sumsqr_window_acc;
    import sumsqr_pkg::*;

    localparam int DW    = 32;
    localparam int WL_A  = 4;
    localparam int AW_A  = calc_acc_w(DW, WL_A);
    localparam int CW_A  = calc_cnt_w(WL_A);
    localparam int WL_B  = 16;
    localparam int AW_B  = calc_acc_w(DW, WL_B);
    localparam int CW_B  = calc_cnt_w(WL_B);

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    sumsqr_window_acc_if #(.DATA_W(DW), .ACC_W(AW_A), .CNT_W(CW_A)) bus_a ();
    sumsqr_window_acc_if #(.DATA_W(DW), .ACC_W(AW_B), .CNT_W(CW_B)) bus_b ();

    sumsqr_window_acc #(.DATA_W(DW), .WIN_LEN(WL_A)) u_dut4 (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus_a.slave)
    );

    sumsqr_window_acc #(.DATA_W(DW), .WIN_LEN(WL_B)) u_dut16 (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic vld, input logic [63:0] sum,
                         input logic [63:0] cnt, input logic rdy);
        chk({tag, ".out_valid"}, 64'(bus_a.out_valid), 64'(vld));
        chk({tag, ".out_sum"},   64'(bus_a.out_sum),   sum);
        chk({tag, ".out_count"}, 64'(bus_a.out_count), cnt);
        chk({tag, ".in_ready"},  64'(bus_a.in_ready),  64'(rdy));
    endtask

    task automatic send_a(input logic [31:0] d, input logic fl);
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = d;
        bus_a.flush    = fl;
        step();
        bus_a.in_valid = 1'b0;
        bus_a.flush    = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus_a.in_data = '0; bus_a.in_valid = 1'b0; bus_a.flush = 1'b0; bus_a.out_ready = 1'b1;
        bus_b.in_data = '0; bus_b.in_valid = 1'b0; bus_b.flush = 1'b0; bus_b.out_ready = 1'b1;

        // Reset state
        step();
        step();
        chk_a("rst_low", 1'b0, 0, 0, 1'b0);
        chk("rst_low.b_valid", 64'(bus_b.out_valid), 64'd0);
        rst_n = 1'b1;
        step();
        chk_a("rst_rel", 1'b0, 0, 0, 1'b1);
        chk("rst_rel.b_ready", 64'(bus_b.in_ready), 64'd1);

        // Back-to-back full window, consumer always ready
        send_a(32'd144, 1'b0); chk_a("w1.s1", 1'b0, 0, 0, 1'b1);
        send_a(32'd145, 1'b0); chk_a("w1.s2", 1'b0, 0, 0, 1'b1);
        send_a(32'd148, 1'b0); chk_a("w1.s3", 1'b0, 0, 0, 1'b1);
        send_a(32'd153, 1'b0); chk_a("w1.res", 1'b1, 590, 4, 1'b0);
        step();
        chk("w1.valid_1cyc", 64'(bus_a.out_valid), 64'd0);
        chk("w1.ready_back", 64'(bus_a.in_ready), 64'd1);

        // Flush together with the third sample
        send_a(32'd144, 1'b0);
        send_a(32'd145, 1'b0);
        send_a(32'd148, 1'b1); chk_a("fl3.res", 1'b1, 437, 3, 1'b0);
        step();
        chk("fl3.done", 64'(bus_a.out_valid), 64'd0);

        // Flush in IDLE with no sample is ignored
        bus_a.flush = 1'b1;
        step();
        bus_a.flush = 1'b0;
        chk_a("fl_idle", 1'b0, 437, 3, 1'b1);
        step();
        chk("fl_idle.later", 64'(bus_a.out_valid), 64'd0);
        for (int i = 0; i < 4; i++) send_a(32'd144, 1'b0);
        chk_a("w576.res", 1'b1, 576, 4, 1'b0);
        step();

        // Back-pressure: result held, samples and flush ignored in HOLD
        bus_a.out_ready = 1'b0;
        send_a(32'd1, 1'b0);
        send_a(32'd2, 1'b0);
        send_a(32'd3, 1'b0);
        send_a(32'd4, 1'b0);
        chk_a("bp.res", 1'b1, 10, 4, 1'b0);
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = 32'd99;
        bus_a.flush    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_a("bp.hold", 1'b1, 10, 4, 1'b0);
        end
        bus_a.in_valid  = 1'b0;
        bus_a.flush     = 1'b0;
        bus_a.out_ready = 1'b1;
        step();
        chk_a("bp.rel", 1'b0, 10, 4, 1'b1);

        // WIN_LEN=16 with all-ones samples: no wrap
        bus_b.in_valid = 1'b1;
        bus_b.in_data  = 32'hFFFF_FFFF;
        for (int i = 0; i < 15; i++) step();
        chk("b.pre_valid", 64'(bus_b.out_valid), 64'd0);
        step();
        bus_b.in_valid = 1'b0;
        chk("b.valid", 64'(bus_b.out_valid), 64'd1);
        chk("b.sum",   64'(bus_b.out_sum),   64'h0000_000F_FFFF_FFF0);
        chk("b.count", 64'(bus_b.out_count), 64'd16);
        step();
        chk("b.done", 64'(bus_b.out_valid), 64'd0);

        // Reset mid-window discards the partial sum
        send_a(32'd144, 1'b0);
        send_a(32'd145, 1'b0);
        rst_n = 1'b0;
        step();
        chk_a("rst_mid", 1'b0, 0, 0, 1'b0);
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 4; i++) send_a(32'd1, 1'b0);
        chk_a("rst_mid.next", 1'b1, 4, 4, 1'b0);
        step();

        // Reset while holding a result
        bus_a.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_a(32'd7, 1'b0);
        chk_a("rst_hold.pre", 1'b1, 28, 4, 1'b0);
        rst_n = 1'b0;
        step();
        chk_a("rst_hold", 1'b0, 0, 0, 1'b0);
        rst_n = 1'b1;
        bus_a.out_ready = 1'b1;
        step();
        chk("rst_hold.ready", 64'(bus_a.in_ready), 64'd1);
        send_a(32'd5, 1'b0);
        send_a(32'd7, 1'b1);
        chk_a("rst_hold.next", 1'b1, 12, 2, 1'b0);
        step();
        chk("rst_hold.done", 64'(bus_a.out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
